// File: rtl/csr_counter_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_counter_unit_if
// Brief    : CSR access bus between the decode/execute stage (master) and the
//            counter unit (slave). Read data and illegal flag are combinational
//            responses in the same cycle as the request.
// Revision : 1.0 - initial release
// ============================================================================
interface csr_counter_unit_if;
  logic        csr_req;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_req, csr_addr, csr_op, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_req, csr_addr, csr_op, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface
`default_nettype wire

// File: rtl/csr_counter_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_counter_unit
// Brief    : cycle / instret / hpm event counters with machine-mode
//            read/write/set/clear access, a per-counter inhibit register and
//            read-only user-mode shadows.
// Revision : 1.0 - initial release
// ============================================================================
module csr_counter_unit #(
  parameter int CNT_WIDTH = 64,
  parameter int NUM_HPM   = 4
) (
  input  wire logic                                   clk,
  input  wire logic                                   rst,
  csr_counter_unit_if.slave                           csr,
  input  wire logic                                   retire,
  input  wire logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_evt
);

  // Counter index space: 0 = cycle, 1 = reserved, 2 = instret, 3.. = hpm.
  localparam int NUM_CNT = 3 + NUM_HPM;
  localparam int HI_W    = CNT_WIDTH - 32;

  // Implemented mcountinhibit bits: 0 and 2..NUM_CNT-1.
  localparam logic [32:0] INH_FULL = ((33'd1 << NUM_CNT) - 33'd1) & ~33'd2;
  localparam logic [31:0] INH_MASK = INH_FULL[31:0];

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Address decode
  logic        w_page_m;
  logic        w_page_u;
  logic        w_hi;
  logic [4:0]  w_idx;
  logic        w_cnt_map;
  logic        w_inh_map;
  logic        w_wr_type;
  logic        w_illegal;
  logic        w_access;
  logic        w_we;

  // Data path
  logic [31:0] w_cnt_rd;
  logic [31:0] w_rd_raw;
  logic [31:0] w_new;

  logic [NUM_CNT-1:0][31:0] w_lo_val;
  logic [NUM_CNT-1:0][31:0] w_hi_val;

  logic [31:0] inh_q;
  logic [31:0] inh_d;

  assign w_page_m  = (csr.csr_addr[11:8] == 4'hB);
  assign w_page_u  = (csr.csr_addr[11:8] == 4'hC);
  assign w_hi      = csr.csr_addr[7];
  assign w_idx     = csr.csr_addr[4:0];
  assign w_cnt_map = (w_page_m || w_page_u) && (csr.csr_addr[6:5] == 2'b00)
                     && ({1'b0, w_idx} < 6'(NUM_CNT));
  assign w_inh_map = (csr.csr_addr == 12'h320);

  // Set/clear with an all-zero mask never modifies state, so it is a read.
  assign w_wr_type = (csr.csr_op == OP_WRITE)
                     || (csr.csr_op[1] && (csr.csr_wdata != 32'd0));

  assign w_illegal = csr.csr_req
                     && (!(w_cnt_map || w_inh_map) || (w_cnt_map && w_page_u && w_wr_type));
  assign w_access  = csr.csr_req && !w_illegal;
  // Legal write-type accesses can only target machine counters or inhibit.
  assign w_we      = w_access && w_wr_type;

  // Select the addressed counter half; high halves are zero-extended.
  always_comb begin
    w_cnt_rd = 32'd0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (w_idx == 5'(k)) begin
        w_cnt_rd = w_hi ? w_hi_val[k] : w_lo_val[k];
      end
    end
  end

  assign w_rd_raw = w_inh_map ? inh_q : w_cnt_rd;

  // Compute the value a write-type op would store into the addressed half.
  always_comb begin
    w_new = w_rd_raw;
    unique case (csr.csr_op)
      OP_WRITE: w_new = csr.csr_wdata;
      OP_SET:   w_new = w_rd_raw | csr.csr_wdata;
      OP_CLEAR: w_new = w_rd_raw & ~csr.csr_wdata;
      OP_READ:  w_new = w_rd_raw;
      default:  w_new = w_rd_raw;
    endcase
  end

  assign csr.csr_rdata   = w_access ? w_rd_raw : 32'd0;
  assign csr.csr_illegal = w_illegal;

  // Next inhibit value: only implemented bits are writable.
  always_comb begin
    inh_d = inh_q;
    if (w_we && w_inh_map) begin
      inh_d = w_new & INH_MASK;
    end
  end

  // Inhibit register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inh_q <= 32'd0;
    end else begin
      inh_q <= inh_d;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CNT; k++) begin : g_ctr
      if (k == 1) begin : g_rsvd
        // Reserved slot: no storage, always reads zero.
        assign w_lo_val[k] = 32'd0;
        assign w_hi_val[k] = 32'd0;
      end else begin : g_cnt
        logic                 w_evt;
        logic                 w_wr_lo;
        logic                 w_wr_hi;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;

        if (k == 0) begin : g_evt_cycle
          assign w_evt = 1'b1;
        end else if (k == 2) begin : g_evt_instret
          assign w_evt = retire;
        end else begin : g_evt_hpm
          assign w_evt = hpm_evt[k-3];
        end

        assign w_wr_lo = w_we && w_cnt_map && !w_hi && (w_idx == 5'(k));
        assign w_wr_hi = w_we && w_cnt_map &&  w_hi && (w_idx == 5'(k));

        // A write to either half freezes the whole counter on that edge,
        // so no increment and no carry across the halves.
        always_comb begin
          cnt_d = cnt_q;
          if (w_wr_lo) begin
            cnt_d = {cnt_q[CNT_WIDTH-1:32], w_new};
          end else if (w_wr_hi) begin
            cnt_d = {w_new[HI_W-1:0], cnt_q[31:0]};
          end else if (w_evt && !inh_q[k]) begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // Counter storage, cleared asynchronously.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        assign w_lo_val[k] = cnt_q[31:0];
        assign w_hi_val[k] = 32'(cnt_q[CNT_WIDTH-1:32]);
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_csr_counter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_counter_unit
// Brief    : Scoreboard bench for csr_counter_unit (CNT_WIDTH=40, NUM_HPM=4).
//            Stimulus pushes expected responses; a negedge monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_counter_unit;

  localparam int CNT_WIDTH = 40;
  localparam int NUM_HPM   = 4;

  logic                clk;
  logic                rst;
  logic                retire;
  logic [NUM_HPM-1:0]  hpm_evt;

  csr_counter_unit_if csr ();

  csr_counter_unit #(
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_HPM   (NUM_HPM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .csr     (csr),
    .retire  (retire),
    .hpm_evt (hpm_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [32:0] exp_q[$];
  string       name_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  // Monitor: every request cycle pops one expected {illegal, rdata}; idle
  // cycles must present zero outputs.
  always @(negedge clk) begin
    logic [32:0] e;
    string       nm;
    if (csr.csr_req) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_req: rdata=%h illegal=%0b, no expected entry",
                 csr.csr_rdata, csr.csr_illegal);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({csr.csr_illegal, csr.csr_rdata} === e) n_pass++;
        else $display("FAIL %s: got rdata=%h illegal=%0b, want rdata=%h illegal=%0b",
                      nm, csr.csr_rdata, csr.csr_illegal, e[31:0], e[32]);
      end
    end else begin
      n_total++;
      if (csr.csr_rdata === 32'd0 && csr.csr_illegal === 1'b0) n_pass++;
      else $display("FAIL idle: got rdata=%h illegal=%0b, want rdata=0 illegal=0",
                    csr.csr_rdata, csr.csr_illegal);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic acc(input logic [11:0] a, input logic [1:0] op,
                     input logic [31:0] wd, input logic [31:0] er,
                     input logic ei, input string nm);
    csr.csr_req   = 1'b1;
    csr.csr_addr  = a;
    csr.csr_op    = op;
    csr.csr_wdata = wd;
    exp_q.push_back({ei, er});
    name_q.push_back(nm);
    tick();
    csr.csr_req   = 1'b0;
    csr.csr_addr  = 12'd0;
    csr.csr_op    = 2'b00;
    csr.csr_wdata = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Interval n below = time between posedge n and n+1 after reset release.
  initial begin
    rst           = 1'b1;
    retire        = 1'b0;
    hpm_evt       = '0;
    csr.csr_req   = 1'b0;
    csr.csr_addr  = 12'd0;
    csr.csr_op    = 2'b00;
    csr.csr_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and free-running cycle counter
    acc(12'hC00, 2'b00, 32'd0, 32'd0,  1'b0, "reset_cycle");       // i0
    idle(9);
    acc(12'hC00, 2'b00, 32'd0, 32'd10, 1'b0, "cycle_10");          // i10
    acc(12'hC02, 2'b00, 32'd0, 32'd0,  1'b0, "instret_0");         // i11
    acc(12'hC80, 2'b00, 32'd0, 32'd0,  1'b0, "cycleh_0");          // i12

    // instret carry from low into high half
    acc(12'hB02, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, "wr_instret_lo"); // i13
    acc(12'hB82, 2'b01, 32'd0,         32'd0, 1'b0, "wr_instret_hi"); // i14
    retire = 1'b1;
    idle(1);                                                        // i15
    retire = 1'b0;
    acc(12'hC02, 2'b00, 32'd0, 32'd0, 1'b0, "instret_lo_wrap");    // i16
    acc(12'hC82, 2'b00, 32'd0, 32'd1, 1'b0, "instret_hi_carry");   // i17
    acc(12'hB01, 2'b00, 32'd0, 32'd0, 1'b0, "reserved_k1");        // i18

    // Write wins over increment on the write edge
    acc(12'hB00, 2'b01, 32'h100, 32'd19,  1'b0, "wr_cycle");       // i19
    acc(12'hB00, 2'b00, 32'd0,   32'h100, 1'b0, "cycle_no_inc");   // i20
    acc(12'hB00, 2'b00, 32'd0,   32'h101, 1'b0, "cycle_resume");   // i21
    acc(12'hB80, 2'b00, 32'd0,   32'd0,   1'b0, "cycleh_kept");    // i22

    // Inhibit instret
    acc(12'h320, 2'b01, 32'h4, 32'd0, 1'b0, "wr_inhibit");         // i23
    acc(12'h320, 2'b00, 32'd0, 32'h4, 1'b0, "rd_inhibit");         // i24
    retire = 1'b1;
    idle(5);                                                        // i25..i29
    retire = 1'b0;
    acc(12'hC02, 2'b00, 32'd0, 32'd0,     1'b0, "instret_inhib");  // i30
    acc(12'hC00, 2'b00, 32'd0, 32'h10B,   1'b0, "cycle_counting"); // i31
    acc(12'h320, 2'b11, 32'h4, 32'h4,     1'b0, "clr_inhibit");    // i32
    retire = 1'b1;
    idle(5);                                                        // i33..i37
    retire = 1'b0;
    acc(12'hC02, 2'b00, 32'd0, 32'd5,     1'b0, "instret_plus5");  // i38

    // Illegal accesses
    acc(12'hC00, 2'b01, 32'h55, 32'd0,    1'b1, "ill_wr_shadow");  // i39
    acc(12'hC00, 2'b10, 32'd0,  32'h114,  1'b0, "set0_shadow");    // i40
    acc(12'hB07, 2'b00, 32'd0,  32'd0,    1'b1, "ill_hpm_range");  // i41
    acc(12'hC00, 2'b00, 32'd0,  32'h116,  1'b0, "cycle_unharmed"); // i42
    acc(12'h321, 2'b00, 32'd0,  32'd0,    1'b1, "ill_unmapped");   // i43
    acc(12'hC82, 2'b11, 32'h1,  32'd0,    1'b1, "ill_clr_shadow"); // i44

    // 40-bit width: high half is 8 bits, wrap to zero
    acc(12'hB83, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, "wr_hpm3_hi");  // i45
    acc(12'hB83, 2'b00, 32'd0, 32'hFF,        1'b0, "hpm3_hi_ff");  // i46
    acc(12'hB03, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, "wr_hpm3_lo");  // i47
    acc(12'hC03, 2'b00, 32'd0, 32'hFFFF_FFFF, 1'b0, "hpm3_lo_max"); // i48
    acc(12'hC83, 2'b00, 32'd0, 32'hFF,        1'b0, "hpm3_hi_max"); // i49
    hpm_evt = 4'b0001;
    idle(1);                                                         // i50
    hpm_evt = 4'b0000;
    acc(12'hC03, 2'b00, 32'd0, 32'd0, 1'b0, "hpm3_wrap_lo");        // i51
    acc(12'hC83, 2'b00, 32'd0, 32'd0, 1'b0, "hpm3_wrap_hi");        // i52

    // Low-half write with concurrent event: no increment that edge
    hpm_evt = 4'b0010;
    acc(12'hB04, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, "wr_hpm4_lo");  // i53
    acc(12'hC84, 2'b00, 32'd0, 32'd0,         1'b0, "hpm4_hi_pre"); // i54
    hpm_evt = 4'b0000;
    acc(12'hC04, 2'b00, 32'd0, 32'd0, 1'b0, "hpm4_lo_carry");       // i55
    acc(12'hC84, 2'b00, 32'd0, 32'd1, 1'b0, "hpm4_hi_carry");       // i56

    // High-half write while low would wrap: carry suppressed
    acc(12'hB05, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, "wr_hpm5_lo");  // i57
    hpm_evt = 4'b0100;
    acc(12'hB85, 2'b01, 32'h10, 32'd0,        1'b0, "wr_hpm5_hi");  // i58
    hpm_evt = 4'b0000;
    acc(12'hC05, 2'b00, 32'd0, 32'hFFFF_FFFF, 1'b0, "hpm5_lo_held"); // i59
    acc(12'hC85, 2'b00, 32'd0, 32'h10,        1'b0, "hpm5_hi_wr");   // i60

    // Inhibit everything; unimplemented bits read zero
    acc(12'h320, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, "wr_inh_all");  // i61
    acc(12'h320, 2'b00, 32'd0, 32'h7D,   1'b0, "inh_mask");         // i62
    acc(12'hC00, 2'b00, 32'd0, 32'h12A,  1'b0, "cycle_frozen_a");   // i63
    acc(12'hC00, 2'b00, 32'd0, 32'h12A,  1'b0, "cycle_frozen_b");   // i64

    // Reset in the middle of a write: write is lost, state cleared
    csr.csr_req   = 1'b1;
    csr.csr_addr  = 12'hB02;
    csr.csr_op    = 2'b01;
    csr.csr_wdata = 32'h1234;
    exp_q.push_back({1'b0, 32'd0});
    name_q.push_back("wr_during_rst");
    #1 rst = 1'b1;
    tick();
    csr.csr_req   = 1'b0;
    csr.csr_addr  = 12'd0;
    csr.csr_op    = 2'b00;
    csr.csr_wdata = 32'd0;
    rst = 1'b0;
    acc(12'hC02, 2'b00, 32'd0, 32'd0, 1'b0, "rst_wr_lost");
    acc(12'hC00, 2'b00, 32'd0, 32'd1, 1'b0, "rst_cycle");
    acc(12'h320, 2'b00, 32'd0, 32'd0, 1'b0, "rst_inhibit");

    begin
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 10) begin
        tick();
        waited++;
      end
    end
    @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending responses, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_counter_unit.md
Name: csr_counter_unit

Overview:
- Parametrised successor to the read-only cycle/instret CSR block.
- Provides the cycle and instret counters plus NUM_HPM event counters, each CNT_WIDTH bits wide, with machine-mode read/write/set/clear access and a per-counter inhibit register.
- Exposes read-only user-mode shadows.
- Sits beside the decode/execute stage. Retire and event strobes come from the pipeline.

Parameters:
- CNT_WIDTH, 64, width of every counter; legal 33..64.
- NUM_HPM, 4, number of hpm event counters (mhpmcounter3 onward); legal 0..29.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- csr_req  in  1  CSR access valid this cycle
- csr_addr  in  12  CSR address
- csr_op  in  2  00 read, 01 write, 10 set, 11 clear
- csr_wdata  in  32  write/mask operand
- csr_rdata  out  32  read data, combinational
- csr_illegal  out  1  access illegal, combinational
- retire  in  1  one instruction retired this cycle
- hpm_evt  in  max(NUM_HPM,1)  per-counter event strobe; bit i feeds mhpmcounter(3+i)

Behaviour:
- Reset: all counters 0; mcountinhibit 0. csr_rdata follows the comb rules below; with csr_req=0 it is 0 and csr_illegal is 0.
- Counter index k:
  - 0 = cycle; 2 = instret; 3..2+NUM_HPM = hpm.
  - k=1 is reserved: reads 0, writes ignored, and it never counts.
- Address map:
  - Low halves: machine 0xB00+k (RW); user shadow 0xC00+k (RO).
  - High halves: 0xB80+k (RW); 0xC80+k (RO).
  - mcountinhibit: 0x320 (RW). Only bits 0, 2, 3..2+NUM_HPM are implemented; all other bits read 0 and ignore writes.
- Increment per cycle, per counter, when not inhibited:
  - cycle: +1 every cycle.
  - instret: +1 when retire=1.
  - hpm i: +1 when hpm_evt[i]=1.
- Wrap: at 2^CNT_WIDTH-1, increment goes to 0 in the same cycle. No sticky flag.
- Width rule:
  - High half reads return counter[CNT_WIDTH-1:32], zero-extended.
  - Writes to the high half only affect bits [CNT_WIDTH-1:32]; excess wdata bits are discarded.
- Read semantics:
  - csr_rdata presents the pre-edge register value in the same cycle as csr_req. There is no pipeline compensation; the bench accounts for in-flight retires.
- Write value: new = wdata (write), old|wdata (set), old&~wdata (clear). It is applied at the next posedge.
- Write suppression: set/clear with wdata==0 is a pure read; no write occurs and it is never illegal due to RO.
- Write vs increment, same cycle:
  - The written half takes the written value, with no increment on that edge.
  - The unwritten half of the same counter also holds; the carry from the low half is suppressed on that edge.
- Write to mcountinhibit takes effect for increments from the following edge onward.
- Illegal (csr_illegal=1, no state change, csr_rdata=0):
  - Unmapped address, including hpm indices ≥3+NUM_HPM.
  - Any write-type op (write, or set/clear with wdata≠0) to a 0xC00/0xC80 shadow.
- csr_req=0: no access; csr_rdata=0, csr_illegal=0. Counting continues.
- Reset mid-operation: asynchronous clear of all state; a pending write is lost.

Test Plan:
- Reset, then 10 idle cycles with retire=0 -> read 0xC00 returns 10; 0xC02 returns 0; 0xC80 returns 0.
- Write 0xB02=0xFFFF_FFFF and 0xB82=0; then one cycle with retire=1 -> 0xC02 reads 0, 0xC82 reads 1.
- Write 0xB00=0x100 while counting -> the next-cycle read of 0xB00 returns 0x100 (no +1 on the write edge), then 0x101.
- Write 0x320=0x4, then retire held high 5 cycles -> instret unchanged; cycle keeps counting. Clear bit 2 -> instret +5 over the next 5 retire cycles.
- Illegal accesses:
  - csr_op=01 to 0xC00 -> csr_illegal=1, counter unaffected.
  - set with wdata=0 to 0xC00 -> csr_illegal=0, returns value.
  - read 0xB03+NUM_HPM -> csr_illegal=1.
- CNT_WIDTH=40:
  - Write 0xB83=0xFFFF_FFFF -> reads back 0xFF.
  - Set counter to 2^40-1, pulse hpm_evt[0] -> wraps to 0.
